tach_pulse_generator: RTL and testbench

- Tachometer emulator: converts a commanded RPM into a square-wave tachometer pulse train on the same 125 MHz clock domain.
- Drives the tachometer_interface input path in hardware-in-the-loop bring-up and closed-loop PID simulation, replacing a physical motor encoder.
- Period (clocks) = K / rpm, with K = CLK_HZ*60/PULSES_PER_REV, computed by an iterative divider.
- New periods are applied only at pulse-period boundaries, so the output never glitches.

---
 rtl/tach_pkg.sv | 30 +++
 rtl/tach_period_divider.sv | 96 +++++++++
 rtl/tach_pulse_generator.sv | 137 +++++++++++++
 tb/tb_tach_pulse_generator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tach_pkg.sv
// Shared constants and types for the tachometer pulse generator.
// TACH_K is the clocks-per-pulse numerator; period = TACH_K / rpm.
package tach_pkg;

    localparam longint unsigned CLK_HZ         = 125_000_000;
    localparam longint unsigned PULSES_PER_REV = 360;
    localparam int              RPM_W          = 21;
    localparam int              PER_W          = 25;

    localparam longint unsigned TACH_K_FULL = (CLK_HZ * 64'd60) / PULSES_PER_REV;
    localparam logic [PER_W-1:0] TACH_K     = PER_W'(TACH_K_FULL);

    // Divider iteration counter must count 0..PER_W-1.
    localparam int CNT_W = $clog2(PER_W + 1);

    typedef logic [PER_W-1:0] period_t;
    typedef logic [RPM_W-1:0] rpm_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_BUSY,
        D_DONE
    } div_state_e;

    typedef enum logic {
        P_STOP,
        P_RUN
    } pulse_state_e;

endpackage

// File: rtl/tach_period_divider.sv
// Iterative restoring divider computing TACH_K / divisor, one quotient bit per clock.
// A zero divisor yields 0 (stop); a quotient of 1 is raised to 2 so a pulse has both phases.
module tach_period_divider
    import tach_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    input  rpm_t    divisor,
    output logic    ready,
    output logic    done,
    output period_t quotient
);

    localparam int REM_W = RPM_W + 1;

    div_state_e       state_reg, state_next;
    rpm_t             divisor_reg, divisor_next;
    logic [REM_W-1:0] rem_reg, rem_next;
    period_t          num_reg, num_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [REM_W-1:0] rem_shift;
    logic [REM_W:0]   rem_diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= D_IDLE;
            divisor_reg <= '0;
            rem_reg     <= '0;
            num_reg     <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            divisor_reg <= divisor_next;
            rem_reg     <= rem_next;
            num_reg     <= num_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // The numerator shifts out MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        state_next   = state_reg;
        divisor_next = divisor_reg;
        rem_next     = rem_reg;
        num_next     = num_reg;
        bit_cnt_next = bit_cnt_reg;
        rem_shift    = {rem_reg[REM_W-2:0], num_reg[PER_W-1]};
        rem_diff     = {1'b0, rem_shift} - {2'b00, divisor_reg};

        case (state_reg)
            D_IDLE: begin
                if (start) begin
                    state_next   = D_BUSY;
                    divisor_next = divisor;
                    rem_next     = '0;
                    num_next     = TACH_K;
                    bit_cnt_next = '0;
                end
            end
            D_BUSY: begin
                if (!rem_diff[REM_W]) begin
                    rem_next = rem_diff[REM_W-1:0];
                    num_next = {num_reg[PER_W-2:0], 1'b1};
                end else begin
                    rem_next = rem_shift;
                    num_next = {num_reg[PER_W-2:0], 1'b0};
                end
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == CNT_W'(PER_W - 1)) begin
                    state_next = D_DONE;
                end
            end
            D_DONE: begin
                state_next = D_IDLE;
            end
            default: begin
                state_next = D_IDLE;
            end
        endcase
    end

    always_comb begin
        if (divisor_reg == '0) begin
            quotient = '0;
        end else if (num_reg == period_t'(1)) begin
            quotient = period_t'(2);
        end else begin
            quotient = num_reg;
        end
    end

    assign ready = (state_reg == D_IDLE);
    assign done  = (state_reg == D_DONE);

endmodule

// File: rtl/tach_pulse_generator.sv
// Tachometer emulator: turns an RPM command into a square pulse train, switching period only at boundaries.
// Define TACH_QUAD_EN to add the quadrature output tachometer_b_out.
module tach_pulse_generator
    import tach_pkg::*;
(
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [RPM_W-1:0] rpm_in,
    input  logic             rpm_valid_in,
    output logic             rpm_ready_out,
    output logic             tachometer_pulse_out,
`ifdef TACH_QUAD_EN
    output logic             tachometer_b_out,
`endif
    output logic [PER_W-1:0] period_out
);

    logic    div_ready;
    logic    div_done;
    period_t div_q;

    tach_period_divider u_divider (
        .clk      (clk_in),
        .rst_n    (reset_n_in),
        .start    (rpm_valid_in && div_ready),
        .divisor  (rpm_in),
        .ready    (div_ready),
        .done     (div_done),
        .quotient (div_q)
    );

    pulse_state_e state_reg, state_next;
    period_t      period_reg, period_next;
    period_t      cnt_reg, cnt_next;
    period_t      pend_reg, pend_next;
    logic         pend_valid_reg, pend_valid_next;
    logic         pulse_reg, pulse_next;
    logic         consume;
    period_t      high_next;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_reg      <= P_STOP;
            period_reg     <= '0;
            cnt_reg        <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pulse_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            period_reg     <= period_next;
            cnt_reg        <= cnt_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            pulse_reg      <= pulse_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        period_next = period_reg;
        cnt_next    = cnt_reg;
        consume     = 1'b0;

        case (state_reg)
            P_STOP: begin
                cnt_next = '0;
                if (pend_valid_reg) begin
                    consume = 1'b1;
                    if (pend_reg != '0) begin
                        state_next  = P_RUN;
                        period_next = pend_reg;
                    end
                end
            end
            P_RUN: begin
                if (cnt_reg == period_reg - period_t'(1)) begin
                    cnt_next = '0;
                    if (pend_valid_reg) begin
                        consume = 1'b1;
                        if (pend_reg != '0) begin
                            period_next = pend_reg;
                        end else begin
                            state_next  = P_STOP;
                            period_next = '0;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + period_t'(1);
                end
            end
            default: begin
                state_next = P_STOP;
            end
        endcase

        // A divider result landing on a boundary cycle is kept for the following boundary.
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        if (consume) begin
            pend_valid_next = 1'b0;
        end
        if (div_done) begin
            pend_next       = div_q;
            pend_valid_next = 1'b1;
        end

        high_next  = period_next >> 1;
        pulse_next = (state_next == P_RUN) && (cnt_next < high_next);
    end

`ifdef TACH_QUAD_EN
    logic    b_reg, b_next;
    period_t quarter_next;

    always_comb begin
        quarter_next = period_next >> 2;
        b_next       = (state_next == P_RUN) && (cnt_next >= quarter_next)
                       && (cnt_next < quarter_next + high_next);
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            b_reg <= 1'b0;
        end else begin
            b_reg <= b_next;
        end
    end

    assign tachometer_b_out = b_reg;
`endif

    assign rpm_ready_out        = div_ready;
    assign tachometer_pulse_out = pulse_reg;
    assign period_out           = period_reg;

endmodule

// File: tb/tb_tach_pulse_generator.sv
// Self-checking bench for tach_pulse_generator: timeline-based reference model plus directed literal checks.
// Build with TACH_QUAD_EN defined to also check the quadrature output.
`timescale 1ns/1ps
module tb_tach_pulse_generator;

    localparam longint MODEL_K = 64'd7_500_000_000 / 64'd360;
    localparam longint DIV_LAT = 26;

    logic        clk_in       = 1'b0;
    logic        reset_n_in   = 1'b0;
    logic        rpm_valid_in = 1'b0;
    logic [20:0] rpm_in       = '0;
    logic        rpm_ready_out;
    logic        tachometer_pulse_out;
    logic [24:0] period_out;
`ifdef TACH_QUAD_EN
    logic        tachometer_b_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #4 clk_in = ~clk_in;

    tach_pulse_generator dut (
        .clk_in               (clk_in),
        .reset_n_in           (reset_n_in),
        .rpm_in               (rpm_in),
        .rpm_valid_in         (rpm_valid_in),
        .rpm_ready_out        (rpm_ready_out),
        .tachometer_pulse_out (tachometer_pulse_out),
`ifdef TACH_QUAD_EN
        .tachometer_b_out     (tachometer_b_out),
`endif
        .period_out           (period_out)
    );

    // Reference model: the pulse train is a timeline of periods, each starting at a known edge number.
    longint edge_no    = 0;
    bit     m_ready    = 1'b1;
    bit     job_busy   = 1'b0;
    longint job_due    = 0;
    longint job_result = 0;
    bit     pend_ok    = 1'b0;
    longint pend_val   = 0;
    bit     running    = 1'b0;
    longint per        = 0;
    longint start_at   = 0;
    bit     model_live = 1'b0;
    bit     old_ready;
    bit     old_pend_ok;
    longint old_pend;

    function automatic longint expected_period(input longint rpm);
        longint q;
        if (rpm == 0) return 0;
        q = MODEL_K / rpm;
        if (q == 1) q = 2;
        return q;
    endfunction

    initial begin
        forever begin
            @(posedge clk_in);
            edge_no++;
            if (!reset_n_in) begin
                m_ready  = 1'b1;
                job_busy = 1'b0;
                pend_ok  = 1'b0;
                pend_val = 0;
                running  = 1'b0;
                per      = 0;
            end else begin
                old_ready   = m_ready;
                old_pend_ok = pend_ok;
                old_pend    = pend_val;
                if (running) begin
                    if (edge_no - start_at == per) begin
                        start_at = edge_no;
                        if (old_pend_ok) begin
                            pend_ok = 1'b0;
                            if (old_pend != 0) per = old_pend;
                            else begin
                                running = 1'b0;
                                per     = 0;
                            end
                        end
                    end
                end else if (old_pend_ok) begin
                    pend_ok = 1'b0;
                    if (old_pend != 0) begin
                        running  = 1'b1;
                        per      = old_pend;
                        start_at = edge_no;
                    end
                end
                if (job_busy && edge_no == job_due) begin
                    pend_ok  = 1'b1;
                    pend_val = job_result;
                    job_busy = 1'b0;
                    m_ready  = 1'b1;
                end
                if (rpm_valid_in && old_ready) begin
                    job_busy   = 1'b1;
                    job_due    = edge_no + DIV_LAT;
                    job_result = expected_period(longint'(rpm_in));
                    m_ready    = 1'b0;
                end
            end
            model_live = 1'b1;
        end
    end

    longint pos;
    bit     exp_pulse;
    longint exp_period;
    bit     exp_b;
    bit     got_b;

    initial begin
        forever begin
            @(negedge clk_in);
            if (model_live) begin
                pos        = edge_no - start_at;
                exp_pulse  = running && (pos < per / 2);
                exp_period = running ? per : 0;
                exp_b      = running && (pos >= per / 4) && (pos < per / 4 + per / 2);
`ifdef TACH_QUAD_EN
                got_b = tachometer_b_out;
`else
                got_b = exp_b;
`endif
                n_cmp++;
                if (tachometer_pulse_out !== exp_pulse || period_out !== 25'(exp_period)
                    || rpm_ready_out !== m_ready || got_b !== exp_b) begin
                    n_bad++;
                    $display("FAIL cycle_check edge=%0d pulse got %b exp %b, period got %0d exp %0d, ready got %b exp %b, b got %b exp %b",
                             edge_no, tachometer_pulse_out, exp_pulse, period_out, exp_period,
                             rpm_ready_out, m_ready, got_b, exp_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic send(input logic [20:0] r);
        int guard;
        guard = 0;
        while (rpm_ready_out !== 1'b1 && guard < 200) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 200) timeout("send_ready");
        rpm_in       = r;
        rpm_valid_in = 1'b1;
        @(negedge clk_in);
        rpm_valid_in = 1'b0;
        $display("sent rpm=%0d", r);
    endtask

    task automatic wait_period_change(input logic [24:0] old, input int limit, output int lat);
        lat = 0;
        while (period_out === old && lat < limit) begin
            @(negedge clk_in);
            lat++;
        end
        if (period_out === old) timeout("period_change");
    endtask

    task automatic count_level(input logic level, input int limit, output int n);
        n = 0;
        while (tachometer_pulse_out === level && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= limit) timeout("count_level");
    endtask

    int lat;
    int hi;
    int lo;

    initial begin
        tick(3);
        check("reset_pulse", tachometer_pulse_out, 0);
        check("reset_period", period_out, 0);
        check("reset_ready", rpm_ready_out, 1);
        reset_n_in = 1'b1;
        tick(2);

        // 300 RPM, then reset part way through the high phase
        send(21'd300);
        check("ready_low_after_accept", rpm_ready_out, 0);
        wait_period_change(25'd0, 200, lat);
        check("run_start_latency", lat, 27);
        check("period_300", period_out, 69444);
        tick(1000);
        check("pulse_high_cnt1000", tachometer_pulse_out, 1);
        reset_n_in = 1'b0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        check("midreset_pulse", tachometer_pulse_out, 0);
        check("midreset_period", period_out, 0);
        check("midreset_ready", rpm_ready_out, 1);
        tick(50);
        check("no_pulse_after_reset", tachometer_pulse_out, 0);

        // 300 RPM high time
        send(21'd300);
        wait_period_change(25'd0, 200, lat);
        count_level(1'b1, 40000, hi);
        check("high_300", hi, 34722);
        do_reset();

        // 1 RPM
        send(21'd1);
        wait_period_change(25'd0, 200, lat);
        check("period_1", period_out, 20833333);
        tick(10);
        check("pulse_1_high", tachometer_pulse_out, 1);
        do_reset();

        // Max RPM
        send(21'd2097151);
        wait_period_change(25'd0, 200, lat);
        check("period_max", period_out, 9);
        count_level(1'b1, 100, hi);
        count_level(1'b0, 100, lo);
        check("high_max", hi, 4);
        check("low_max", lo, 5);
        do_reset();

        // Mid-period change 300000 -> 600000
        send(21'd300000);
        wait_period_change(25'd0, 200, lat);
        check("period_300k", period_out, 69);
        tick(40);
        send(21'd600000);
        wait_period_change(25'd69, 400, lat);
        check("period_600k", period_out, 34);
        count_level(1'b1, 100, hi);
        count_level(1'b0, 100, lo);
        check("high_600k", hi, 17);
        check("low_600k", lo, 17);

        // Stop command
        send(21'd0);
        wait_period_change(25'd34, 400, lat);
        check("stop_pulse", tachometer_pulse_out, 0);
        tick(100);
        check("stop_period", period_out, 0);
        check("stop_pulse_held", tachometer_pulse_out, 0);

        // Command while busy is ignored
        send(21'd100000);
        rpm_in       = 21'd50000;
        rpm_valid_in = 1'b1;
        @(negedge clk_in);
        rpm_valid_in = 1'b0;
        wait_period_change(25'd0, 200, lat);
        check("busy_ignored_period", period_out, 208);

        // Two commands completing before a boundary: last wins
        send(21'd200000);
        send(21'd400000);
        wait_period_change(25'd208, 600, lat);
        check("overwrite_period", period_out, 52);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rpm_valid_in = ($urandom_range(0, 24) == 0);
            rpm_in       = ($urandom_range(0, 9) == 0) ? 21'd0 : 21'($urandom_range(20000, 2097151));
            reset_n_in   = ($urandom_range(0, 1499) != 0);
            @(negedge clk_in);
        end
        rpm_valid_in = 1'b0;
        reset_n_in   = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
